rpm_error_calc: RTL

Measures wheel speed from a quadrature encoder over a fixed sample window and produces the signed speed error consumed by the motor PI controller. It outputs the error in the controller's 17-bit sign-magnitude Q8 format, one value per window. Each motor channel has one instance, placed between the encoder pins and the PI controller's `Error_k` input. A per-window strobe is also generated so downstream logic can use it as its sample clock.

---
 rtl/rpm_error_calc.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rpm_error_calc.sv
// rpm_error_calc: x4 quadrature speed measurement per fixed window, producing a sign-magnitude Q8
// speed and speed error. Optional input glitch filter is built when ENC_GLITCH_FILTER_EN is defined.
module rpm_error_calc #(
    parameter int unsigned        N_WIDTH       = 17,
    parameter int unsigned        Q_WIDTH       = 8,
    parameter int unsigned        SAMPLE_CYCLES = 4100,
    parameter int unsigned        CNT_WIDTH     = 12,
    parameter logic [N_WIDTH-1:0] K_SCALE       = N_WIDTH'(256),
    parameter int unsigned        FILTER_LEN    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic [N_WIDTH-1:0] Setpoint,
    output logic [N_WIDTH-1:0] Speed_k,
    output logic [N_WIDTH-1:0] Error_k,
    output logic               sample_valid,
    output logic               enc_fault
);

    localparam int unsigned MAG_W  = N_WIDTH - 1;
    localparam int unsigned WIN_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned PROD_W = CNT_WIDTH + N_WIDTH;

    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
    localparam logic [MAG_W-1:0]     MAG_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MIN  = {1'b1, {(CNT_WIDTH-2){1'b0}}, 1'b1};

    // Elaboration-time parameter sanity
    if (SAMPLE_CYCLES < 2) begin : g_bad_window
        $error("SAMPLE_CYCLES must be at least 2");
    end
    if (CNT_WIDTH < 3) begin : g_bad_cnt
        $error("CNT_WIDTH must be at least 3");
    end
    if (Q_WIDTH >= N_WIDTH) begin : g_bad_q
        $error("Q_WIDTH must be smaller than N_WIDTH");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end

    // Two-stage synchroniser, free-running so priming after reset sees the settled pin state
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] enc_state;

    always_ff @(posedge clk) begin
        sync1 <= {enc_a, enc_b};
        sync2 <= sync1;
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]        filt_q;
    logic [FCNT_W-1:0] filt_cnt [2];

    // A channel changes only after FILTER_LEN consecutive samples disagree with the held value
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt_q[i]) begin
                filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                filt_q[i]   <= sync2[i];
                filt_cnt[i] <= '0;
            end else begin
                filt_cnt[i] <= filt_cnt[i] + FCNT_W'(1);
            end
        end
    end

    assign enc_state = filt_q;
`else
    assign enc_state = sync2;
`endif

    logic [1:0]           prev_state;
    logic                 primed;
    logic                 step_up;
    logic                 step_dn;
    logic                 step_bad;
    logic [WIN_W-1:0]     win_cnt;
    logic                 win_end;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] cnt_mag;
    logic [PROD_W-1:0]    prod;
    logic [MAG_W-1:0]     speed_mag;
    logic [N_WIDTH-1:0]   speed_next;
    logic [N_WIDTH-1:0]   setpoint_q;
    logic                 speed_vld;
    logic [MAG_W-1:0]     sp_mag;
    logic [MAG_W-1:0]     nsp_mag;
    logic                 sp_sign;
    logic                 nsp_sign;
    logic [MAG_W:0]       mag_sum;
    logic [MAG_W-1:0]     err_mag;
    logic                 err_sign;
    logic [N_WIDTH-1:0]   error_next;

    // x4 decode of {A,B}: forward order 00 -> 01 -> 11 -> 10
    always_comb begin
        step_up  = 1'b0;
        step_dn  = 1'b0;
        step_bad = 1'b0;
        if (primed) begin
            case ({prev_state, enc_state})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up  = 1'b1;
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn  = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating edge counter, symmetric range so the magnitude always fits
    always_comb begin
        cnt_next = edge_cnt;
        if (step_up && (edge_cnt != CNT_MAX)) begin
            cnt_next = edge_cnt + CNT_WIDTH'(1);
        end else if (step_dn && (edge_cnt != CNT_MIN)) begin
            cnt_next = edge_cnt - CNT_WIDTH'(1);
        end
    end

    assign win_end = (win_cnt == WIN_LAST);

    // Speed: integer count times Q8 scale is already Q8
    always_comb begin
        cnt_mag    = cnt_next[CNT_WIDTH-1] ? (~cnt_next + CNT_WIDTH'(1)) : cnt_next;
        prod       = PROD_W'(cnt_mag) * PROD_W'(K_SCALE);
        speed_mag  = (prod > PROD_W'(MAG_MAX)) ? MAG_MAX : prod[MAG_W-1:0];
        speed_next = {cnt_next[CNT_WIDTH-1] && (speed_mag != '0), speed_mag};
    end

    // Error = Setpoint + (-Speed_k) in sign-magnitude, never producing negative zero
    always_comb begin
        sp_sign  = setpoint_q[N_WIDTH-1];
        sp_mag   = setpoint_q[MAG_W-1:0];
        nsp_sign = ~Speed_k[N_WIDTH-1];
        nsp_mag  = Speed_k[MAG_W-1:0];
        mag_sum  = {1'b0, sp_mag} + {1'b0, nsp_mag};
        err_mag  = '0;
        err_sign = 1'b0;
        if (sp_sign == nsp_sign) begin
            err_mag  = mag_sum[MAG_W] ? MAG_MAX : mag_sum[MAG_W-1:0];
            err_sign = sp_sign;
        end else if (sp_mag >= nsp_mag) begin
            err_mag  = sp_mag - nsp_mag;
            err_sign = sp_sign;
        end else begin
            err_mag  = nsp_mag - sp_mag;
            err_sign = nsp_sign;
        end
        error_next = {err_sign && (err_mag != '0), err_mag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            primed       <= 1'b0;
            prev_state   <= '0;
            enc_fault    <= 1'b0;
            win_cnt      <= '0;
            edge_cnt     <= '0;
            setpoint_q   <= '0;
            speed_vld    <= 1'b0;
            Speed_k      <= '0;
            Error_k      <= '0;
            sample_valid <= 1'b0;
        end else begin
            primed     <= 1'b1;
            prev_state <= enc_state;
            if (step_bad) begin
                enc_fault <= 1'b1;
            end
            speed_vld    <= win_end;
            sample_valid <= speed_vld;
            if (win_end) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                Speed_k    <= speed_next;
                setpoint_q <= Setpoint;
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                edge_cnt <= cnt_next;
            end
            if (speed_vld) begin
                Error_k <= error_next;
            end
        end
    end

endmodule
